// File: rtl/card_board_scanner_if.sv
// Board-scan bundle between the regfile read port, the scanner
// and the game logic FSM.
interface card_board_scanner_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 14,
  parameter int CNT_W  = 6
);
  logic              start_scan;
  logic [ADDR_W-1:0] num_of_cards;
  logic [DATA_W-1:0] regfile_r_data;
  logic              read_all_cards;
  logic              busy;
  logic              scan_done;
  logic [CNT_W-1:0]  hidden_cnt;
  logic [CNT_W-1:0]  revealed_cnt;
  logic [CNT_W-1:0]  matched_cnt;
  logic              all_matched;
  logic [ADDR_W-1:0] revealed_addr_0;
  logic [ADDR_W-1:0] revealed_addr_1;
  logic              pair_found;
  logic              invalid_state;

  modport master (
    output start_scan, num_of_cards, regfile_r_data,
    input  read_all_cards, busy, scan_done,
    input  hidden_cnt, revealed_cnt, matched_cnt,
    input  all_matched, revealed_addr_0, revealed_addr_1,
    input  pair_found, invalid_state
  );

  modport slave (
    input  start_scan, num_of_cards, regfile_r_data,
    output read_all_cards, busy, scan_done,
    output hidden_cnt, revealed_cnt, matched_cnt,
    output all_matched, revealed_addr_0, revealed_addr_1,
    output pair_found, invalid_state
  );
endinterface

// File: rtl/card_board_scanner.sv
// Sweeps the card regfile once per request and publishes per-state
// counts, the first two revealed cards and the match verdicts.
module card_board_scanner #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 14,
  parameter int STATE_W      = 2,
  parameter int CNT_W        = 6,
  parameter int FIRST_IDX    = 0,
  parameter int READ_LATENCY = 1,
  parameter logic [STATE_W-1:0] ST_HIDDEN   = 2'b00,
  parameter logic [STATE_W-1:0] ST_REVEALED = 2'b01,
  parameter logic [STATE_W-1:0] ST_MATCHED  = 2'b10
) (
  input logic clk,
  input logic rst,
  card_board_scanner_if.slave bus
);
  localparam int IDW = DATA_W - STATE_W;
  localparam int NW  = ADDR_W + 1;
  localparam int DW  = ADDR_W + 2;

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, COLLECT, DONE
  } state_t;

  state_t             st;
  logic [NW-1:0]      n_q;
  logic [NW-1:0]      k_q;
  logic [1:0]         w_q;
  logic [CNT_W-1:0]   h_a;
  logic [CNT_W-1:0]   r_a;
  logic [CNT_W-1:0]   m_a;
  logic               inv_a;
  logic [ADDR_W-1:0]  a0_a;
  logic [ADDR_W-1:0]  a1_a;
  logic [IDW-1:0]     id0_a;
  logic [IDW-1:0]     id1_a;

  logic [DW-1:0]      diff;
  logic [STATE_W-1:0] ws;
  logic [IDW-1:0]     wid;
  logic [ADDR_W-1:0]  cur;

  // diff goes negative (top bit set) when the last address precedes FIRST_IDX
  assign diff = DW'(bus.num_of_cards) - DW'(FIRST_IDX);
  assign ws   = bus.regfile_r_data[STATE_W-1:0];
  assign wid  = bus.regfile_r_data[DATA_W-1:STATE_W];
  assign cur  = ADDR_W'(FIRST_IDX) + k_q[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      st                  <= IDLE;
      n_q                 <= '0;
      k_q                 <= '0;
      w_q                 <= '0;
      h_a                 <= '0;
      r_a                 <= '0;
      m_a                 <= '0;
      inv_a               <= 1'b0;
      a0_a                <= '0;
      a1_a                <= '0;
      id0_a               <= '0;
      id1_a               <= '0;
      bus.read_all_cards  <= 1'b0;
      bus.busy            <= 1'b0;
      bus.scan_done       <= 1'b0;
      bus.hidden_cnt      <= '0;
      bus.revealed_cnt    <= '0;
      bus.matched_cnt     <= '0;
      bus.all_matched     <= 1'b0;
      bus.revealed_addr_0 <= '0;
      bus.revealed_addr_1 <= '0;
      bus.pair_found      <= 1'b0;
      bus.invalid_state   <= 1'b0;
    end else begin
      bus.read_all_cards <= 1'b0;
      bus.scan_done      <= 1'b0;
      if (bus.scan_done) bus.busy <= 1'b0;
      unique case (st)
        IDLE: begin
          if (bus.start_scan && !bus.busy) begin
            bus.busy <= 1'b1;
            k_q      <= '0;
            w_q      <= '0;
            h_a      <= '0;
            r_a      <= '0;
            m_a      <= '0;
            inv_a    <= 1'b0;
            a0_a     <= '0;
            a1_a     <= '0;
            id0_a    <= '0;
            id1_a    <= '0;
            if (diff[DW-1]) begin
              n_q <= '0;
              st  <= DONE;
            end else begin
              n_q                <= diff[NW-1:0] + NW'(1);
              bus.read_all_cards <= 1'b1;
              st                 <= REQ;
            end
          end
        end
        REQ: st <= WAIT;
        WAIT: begin
          if (w_q == 2'(READ_LATENCY - 1)) st <= COLLECT;
          else w_q <= w_q + 2'd1;
        end
        COLLECT: begin
          unique case (1'b1)
            (ws == ST_HIDDEN):  h_a <= h_a + CNT_W'(1);
            (ws == ST_MATCHED): m_a <= m_a + CNT_W'(1);
            (ws == ST_REVEALED): begin
              r_a <= r_a + CNT_W'(1);
              if (r_a == '0) begin
                a0_a  <= cur;
                id0_a <= wid;
              end else if (r_a == CNT_W'(1)) begin
                a1_a  <= cur;
                id1_a <= wid;
              end
            end
            default: inv_a <= 1'b1;
          endcase
          k_q <= k_q + NW'(1);
          if (k_q == n_q - NW'(1)) st <= DONE;
        end
        DONE: begin
          bus.hidden_cnt      <= h_a;
          bus.revealed_cnt    <= r_a;
          bus.matched_cnt     <= m_a;
          bus.revealed_addr_0 <= a0_a;
          bus.revealed_addr_1 <= a1_a;
          bus.invalid_state   <= inv_a;
          bus.pair_found      <= (r_a == CNT_W'(2)) && (id0_a == id1_a);
          bus.all_matched     <= (m_a == CNT_W'(n_q)) && (n_q != '0);
          bus.scan_done       <= 1'b1;
          st                  <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_card_board_scanner.sv
// Directed bench: two scanners (read latency 1 and 3) share stimulus,
// each fed by its own regfile sweep model.
module tb_card_board_scanner;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [4:0] num = '0;
  logic [13:0] mem [32];
  int p1 = 1000;
  int p3 = 1000;
  int vec = 0;
  int miss = 0;

  always #5 clk = ~clk;

  card_board_scanner_if #(.ADDR_W(5), .DATA_W(14), .CNT_W(6)) b1 ();
  card_board_scanner_if #(.ADDR_W(5), .DATA_W(14), .CNT_W(6)) b3 ();

  card_board_scanner #(.READ_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );
  card_board_scanner #(.READ_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .bus(b3.slave)
  );

  assign b1.start_scan   = start;
  assign b3.start_scan   = start;
  assign b1.num_of_cards = num;
  assign b3.num_of_cards = num;

  // Sweep model: index k is presented READ_LATENCY cycles after address k
  always @(posedge clk) begin
    p1 <= b1.read_all_cards ? -1 : (p1 < 1000 ? p1 + 1 : p1);
    p3 <= b3.read_all_cards ? -3 : (p3 < 1000 ? p3 + 1 : p3);
  end
  assign b1.regfile_r_data = (p1 >= 0 && p1 < 32) ? mem[p1] : 14'h3fff;
  assign b3.regfile_r_data = (p3 >= 0 && p3 < 32) ? mem[p3] : 14'h3fff;

  wire [30:0] r1 = {b1.hidden_cnt, b1.revealed_cnt, b1.matched_cnt,
                    b1.all_matched, b1.revealed_addr_0, b1.revealed_addr_1,
                    b1.pair_found, b1.invalid_state};
  wire [30:0] r3 = {b3.hidden_cnt, b3.revealed_cnt, b3.matched_cnt,
                    b3.all_matched, b3.revealed_addr_0, b3.revealed_addr_1,
                    b3.pair_found, b3.invalid_state};
  wire [5:0] ctl = {b1.busy, b1.scan_done, b1.read_all_cards,
                    b3.busy, b3.scan_done, b3.read_all_cards};

  function automatic logic [30:0] pk(int h, int r, int m, int am,
                                     int a0, int a1, int pf, int inv);
    return {6'(h), 6'(r), 6'(m), 1'(am), 5'(a0), 5'(a1), 1'(pf), 1'(inv)};
  endfunction

  function automatic logic [13:0] w(int id, int st);
    return {12'(id), 2'(st)};
  endfunction

  task automatic fill(input int st);
    for (int i = 0; i < 32; i++) mem[i] = w(i + 1, st);
  endtask

  task automatic run_scan(input logic [4:0] last, input bit spam,
                          output int l1, output int l3,
                          output int nreq, output logic bsy);
    @(negedge clk);
    start = 1'b1;
    num = last;
    l1 = -1;
    l3 = -1;
    nreq = 0;
    bsy = 1'b0;
    for (int c = 1; c <= 80 && (l1 < 0 || l3 < 0); c++) begin
      @(negedge clk);
      start = spam && c < 6 && c[0];
      num = ~last;
      if (b1.read_all_cards) nreq++;
      if (b1.scan_done && l1 < 0) begin
        l1 = c;
        bsy = b1.busy;
      end
      if (b3.scan_done && l3 < 0) l3 = c;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++;
    if (r1 !== '0 || r3 !== '0) begin
      miss++;
      $display("FAIL reset_results: got %h/%h want 0", r1, r3);
    end
    vec++;
    if (ctl !== 6'b0) begin
      miss++;
      $display("FAIL reset_ctl: got %b want 000000", ctl);
    end
    rst = 1'b1;
  endtask

  task automatic test_all_hidden;
    int l1, l3, nreq;
    logic bsy;
    fill(0);
    run_scan(5'd7, 1'b0, l1, l3, nreq, bsy);
    vec++;
    if (l1 !== 12) begin
      miss++;
      $display("FAIL hidden_lat1: got %0d want 12", l1);
    end
    vec++;
    if (l3 !== 14) begin
      miss++;
      $display("FAIL hidden_lat3: got %0d want 14", l3);
    end
    vec++;
    if (nreq !== 1) begin
      miss++;
      $display("FAIL hidden_req: got %0d want 1", nreq);
    end
    vec++;
    if (bsy !== 1'b1) begin
      miss++;
      $display("FAIL hidden_busy_at_done: got %b want 1", bsy);
    end
    vec++;
    if (r1 !== pk(8, 0, 0, 0, 0, 0, 0, 0)) begin
      miss++;
      $display("FAIL hidden_res1: got %h want %h", r1,
               pk(8, 0, 0, 0, 0, 0, 0, 0));
    end
    vec++;
    if (r3 !== pk(8, 0, 0, 0, 0, 0, 0, 0)) begin
      miss++;
      $display("FAIL hidden_res3: got %h want %h", r3,
               pk(8, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_pair(input int id6, input int pf);
    int l1, l3, nreq;
    logic bsy;
    fill(2);
    mem[2] = w(5, 1);
    mem[6] = w(id6, 1);
    run_scan(5'd7, 1'b0, l1, l3, nreq, bsy);
    vec++;
    if (r1 !== pk(0, 2, 6, 0, 2, 6, pf, 0)) begin
      miss++;
      $display("FAIL pair_res1 id6=%0d: got %h want %h", id6, r1,
               pk(0, 2, 6, 0, 2, 6, pf, 0));
    end
    vec++;
    if (r3 !== pk(0, 2, 6, 0, 2, 6, pf, 0)) begin
      miss++;
      $display("FAIL pair_res3 id6=%0d: got %h want %h", id6, r3,
               pk(0, 2, 6, 0, 2, 6, pf, 0));
    end
  endtask

  task automatic test_all_matched;
    int l1, l3, nreq;
    logic bsy;
    fill(2);
    run_scan(5'd31, 1'b0, l1, l3, nreq, bsy);
    vec++;
    if (r1 !== pk(0, 0, 32, 1, 0, 0, 0, 0)) begin
      miss++;
      $display("FAIL matched_res1: got %h want %h", r1,
               pk(0, 0, 32, 1, 0, 0, 0, 0));
    end
    vec++;
    if (r3 !== pk(0, 0, 32, 1, 0, 0, 0, 0)) begin
      miss++;
      $display("FAIL matched_res3: got %h want %h", r3,
               pk(0, 0, 32, 1, 0, 0, 0, 0));
    end
    vec++;
    if (l1 !== 36) begin
      miss++;
      $display("FAIL matched_lat1: got %0d want 36", l1);
    end
    vec++;
    if (l3 !== 38) begin
      miss++;
      $display("FAIL matched_lat3: got %0d want 38", l3);
    end
  endtask

  task automatic load_invalid;
    fill(0);
    mem[3] = w(0, 3);
    mem[1] = w(7, 1);
    mem[4] = w(7, 1);
    mem[9] = w(7, 1);
  endtask

  task automatic test_invalid_busy;
    int l1, l3, nreq;
    logic bsy;
    load_invalid();
    run_scan(5'd9, 1'b1, l1, l3, nreq, bsy);
    vec++;
    if (r1 !== pk(6, 3, 0, 0, 1, 4, 0, 1)) begin
      miss++;
      $display("FAIL invalid_res1: got %h want %h", r1,
               pk(6, 3, 0, 0, 1, 4, 0, 1));
    end
    vec++;
    if (r3 !== pk(6, 3, 0, 0, 1, 4, 0, 1)) begin
      miss++;
      $display("FAIL invalid_res3: got %h want %h", r3,
               pk(6, 3, 0, 0, 1, 4, 0, 1));
    end
    vec++;
    if (nreq !== 1) begin
      miss++;
      $display("FAIL busy_single_req: got %0d want 1", nreq);
    end
    vec++;
    if (l1 !== 14) begin
      miss++;
      $display("FAIL invalid_lat1: got %0d want 14", l1);
    end
  endtask

  task automatic test_reset_abort;
    int l1, l3, nreq, nd;
    logic bsy;
    load_invalid();
    mem[3] = w(0, 0);
    @(negedge clk);
    start = 1'b1;
    num = 5'd9;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) rst = 1'b0;
      if (c == 7) rst = 1'b1;
    end
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b1.scan_done || b3.scan_done) nd++;
    end
    vec++;
    if (nd !== 0) begin
      miss++;
      $display("FAIL abort_no_done: got %0d pulses want 0", nd);
    end
    vec++;
    if (r1 !== '0 || ctl !== 6'b0) begin
      miss++;
      $display("FAIL abort_cleared: got %h ctl %b want 0", r1, ctl);
    end
    run_scan(5'd9, 1'b0, l1, l3, nreq, bsy);
    vec++;
    if (r1 !== pk(7, 3, 0, 0, 1, 4, 0, 0)) begin
      miss++;
      $display("FAIL rescan_res1: got %h want %h", r1,
               pk(7, 3, 0, 0, 1, 4, 0, 0));
    end
    vec++;
    if (r3 !== pk(7, 3, 0, 0, 1, 4, 0, 0)) begin
      miss++;
      $display("FAIL rescan_res3: got %h want %h", r3,
               pk(7, 3, 0, 0, 1, 4, 0, 0));
    end
    vec++;
    if (l1 !== 14 || l3 !== 16) begin
      miss++;
      $display("FAIL rescan_lat: got %0d/%0d want 14/16", l1, l3);
    end
  endtask

  initial begin
    fill(0);
    test_reset();
    test_all_hidden();
    test_pair(5, 1);
    test_pair(9, 0);
    test_all_matched();
    test_invalid_busy();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/card_board_scanner.md
Name: card_board_scanner

Overview:
- Consumer at the read side of the card register file: requests a full-board sweep from the regfile control unit and collects the streamed card words.
- Produces per-state card counts, the addresses of the first two face-up cards, a pair-match verdict and an all-matched (game won) flag.
- Sits between the regfile read port and the game logic FSM.
- Results are published atomically at the end of each sweep.

Parameters:
- ADDR_W, 5, card address width.
- DATA_W, 14, card word width; state in [STATE_W-1:0], card id in [DATA_W-1:STATE_W].
- STATE_W, 2, card state field width.
- CNT_W, 6, counter width (holds 0..32).
- FIRST_IDX, 0, address of first card in a sweep.
- READ_LATENCY, 1, cycles from regfile read address to valid read data (1..3).
- ST_HIDDEN, 2'b00, hidden state code.
- ST_REVEALED, 2'b01, revealed state code.
- ST_MATCHED, 2'b10, matched state code.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- start_scan  in  1  one-cycle request to scan the board.
- num_of_cards  in  ADDR_W  last card address of the sweep; sampled on accepted start.
- regfile_r_data  in  DATA_W  regfile read data.
- read_all_cards  out  1  one-cycle sweep request to regfile control.
- busy  out  1  high from accepted start to scan_done inclusive.
- scan_done  out  1  one-cycle pulse when results update.
- hidden_cnt  out  CNT_W  hidden cards in last sweep.
- revealed_cnt  out  CNT_W  revealed cards in last sweep.
- matched_cnt  out  CNT_W  matched cards in last sweep.
- all_matched  out  1  every swept card matched; sweep not empty.
- revealed_addr_0  out  ADDR_W  lowest address with revealed state.
- revealed_addr_1  out  ADDR_W  second-lowest address with revealed state.
- pair_found  out  1  exactly two revealed cards with equal card id.
- invalid_state  out  1  at least one card had state 2'b11.

Behaviour:
- Reset (rst==0 at posedge): FSM to IDLE, all outputs and internal accumulators 0. Reset mid-sweep aborts silently with no scan_done.
- FSM states: IDLE, REQ, WAIT, COLLECT, DONE.
- IDLE: start_scan==1 latches last=num_of_cards and N=last-FIRST_IDX+1, then goes to REQ.
  - If last<FIRST_IDX, go directly to DONE with zero counts. read_all_cards is never asserted in this case.
- REQ (1 cycle): read_all_cards=1; accumulators cleared.
- Sweep timing: the controller presents address FIRST_IDX on the cycle after REQ, incrementing by 1 per cycle. Data for sweep element k (k=0..N-1) is valid at REQ+1+READ_LATENCY+k.
- WAIT: count READ_LATENCY cycles, then go to COLLECT.
- COLLECT: one word per cycle for exactly N cycles. A local address counter tracks FIRST_IDX+k.
  - Decode state: hidden, revealed or matched increments its counter. Code 2'b11 sets the invalid flag and increments no counter.
  - Revealed: the first occurrence records address and id into slot 0, the second into slot 1; later occurrences only count.
  - After the Nth word, go to DONE.
- DONE (1 cycle): copy accumulators to outputs in the same edge; scan_done=1; return to IDLE.
  - pair_found = (revealed count==2) && (id0==id1).
  - all_matched = (matched count==N) && (N>0).
  - Unused revealed slots output address 0.
- Outputs hold their values between scans. busy=1 in REQ, WAIT, COLLECT and DONE.
- start_scan while busy is ignored and not queued. start_scan in the DONE cycle is ignored.
- num_of_cards changes during a sweep have no effect.
- Counter width: CNT_W must satisfy 2^CNT_W > 2^ADDR_W so counters never wrap; no saturation logic.
- Latency from start_scan to scan_done: 3+READ_LATENCY+N cycles for N>0; 2 cycles for an empty sweep.

Test Plan:
- Reset, then 8 cards (addr 0..7) all hidden, READ_LATENCY=1, start_scan -> read_all_cards one cycle later. scan_done 12 cycles after start; hidden=8, revealed=0, matched=0, all_matched=0, pair_found=0.
- Addr 2 revealed id 5, addr 6 revealed id 5, rest matched, num_of_cards=7 -> revealed_cnt=2, matched_cnt=6, revealed_addr_0=2, revealed_addr_1=6, pair_found=1.
- Same setup but addr 6 id 9 -> pair_found=0, addresses still 2 and 6.
- All 32 cards matched, num_of_cards=31 -> matched_cnt=32, all_matched=1, no counter wrap.
- Addr 3 state 2'b11, three revealed cards -> invalid_state=1, revealed_cnt=3, pair_found=0. Repeated start_scan pulses while busy produce exactly one read_all_cards.
- Drive rst low during COLLECT, release, start new scan -> no scan_done from the aborted sweep; new results are correct. With READ_LATENCY=3, the same data gives identical counts, 2 cycles later.
